// File: rtl/align_pp_lanes_pipe_if.sv
// Beat bus for the partial-product alignment stage: upstream beat in, aligned beat out.
// Carries no state and adds no latency.
// Flow control is valid/ready on both sides.
interface align_pp_lanes_pipe_if #(
  parameter int LANES   = 4,
  parameter int PP_W    = 3,
  parameter int EXP_W   = 6,
  parameter int ALIGN_W = 14,
  parameter int QF_W    = 5
);
  logic                         i_valid;
  logic                         o_ready;
  logic [LANES*(PP_W+1)-1:0]    i_pp;
  logic [LANES*EXP_W-1:0]       i_exp;
  logic [EXP_W-1:0]             i_max_exp;
  logic [QF_W-1:0]              i_Q_frac;
  logic                         o_valid;
  logic                         i_ready;
  logic [LANES*(ALIGN_W+1)-1:0] o_align_pp;
  logic [LANES-1:0]             o_sticky;
  logic [LANES-1:0]             o_exp_err;
  logic [EXP_W-1:0]             o_max_exp;
  logic [QF_W-1:0]              o_Q_frac;

  // Block side.
  modport slave (
    input  i_valid, i_pp, i_exp, i_max_exp, i_Q_frac, i_ready,
    output o_ready, o_valid, o_align_pp, o_sticky, o_exp_err, o_max_exp, o_Q_frac
  );

  // Upstream/downstream side.
  modport master (
    output i_valid, i_pp, i_exp, i_max_exp, i_Q_frac, i_ready,
    input  o_ready, o_valid, o_align_pp, o_sticky, o_exp_err, o_max_exp, o_Q_frac
  );
endinterface

// File: rtl/align_pp_lanes_pipe.sv
// Per-lane right-shift of sign-magnitude partial products to the shared max exponent, sticky collection, two's-complement conversion.
// Latency 2 cycles accept->o_valid, 1 beat/cycle.
// Backpressure: o_ready = ~s1_valid | ~s2_valid | i_ready; outputs hold while o_valid & ~i_ready.
module align_pp_lanes_pipe #(
  parameter int LANES   = 4,
  parameter int PP_W    = 3,
  parameter int EXP_W   = 6,
  parameter int ALIGN_W = 14,
  parameter int QF_W    = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  align_pp_lanes_pipe_if.slave bus
);
  localparam int SH = ALIGN_W - PP_W;
  localparam int OW = ALIGN_W + 1;

  // Stage 1 state: unsigned shifted magnitude plus sign per lane.
  logic                              r_s1_valid;
  logic [LANES-1:0][ALIGN_W-1:0]     r_s1_shift;
  logic [LANES-1:0]                  r_s1_sign;
  logic [LANES-1:0]                  r_s1_sticky;
  logic [LANES-1:0]                  r_s1_err;
  logic [EXP_W-1:0]                  r_s1_max_exp;
  logic [QF_W-1:0]                   r_s1_qf;

  // Stage 2 state: two's-complement result per lane.
  logic                              r_s2_valid;
  logic [LANES-1:0][OW-1:0]          r_s2_align;
  logic [LANES-1:0]                  r_s2_sticky;
  logic [LANES-1:0]                  r_s2_err;
  logic [EXP_W-1:0]                  r_s2_max_exp;
  logic [QF_W-1:0]                   r_s2_qf;

  logic                              w_adv2;
  logic                              w_acc;
  logic                              w_load2;

  logic [LANES-1:0][PP_W-1:0]        w_mag;
  logic [LANES-1:0]                  w_sign;
  logic [LANES-1:0][EXP_W-1:0]       w_d;
  logic [LANES-1:0]                  w_b;
  logic [LANES-1:0][ALIGN_W-1:0]     w_full;
  logic [LANES-1:0][ALIGN_W-1:0]     w_shift;
  logic [LANES-1:0]                  w_sticky;
  logic [LANES-1:0]                  w_err;
  logic [LANES-1:0][OW-1:0]          w_tc;

  // Stage 2 frees up when empty or drained this cycle; stage 1 frees up when empty or moving on.
  assign w_adv2      = ~r_s2_valid | bus.i_ready;
  assign bus.o_ready = ~r_s1_valid | w_adv2;
  assign w_acc       = bus.i_valid & bus.o_ready;
  assign w_load2     = w_adv2 & r_s1_valid;

  // Stage 1 combinational: exponent difference, alignment shift and sticky per lane.
  always_comb begin
    w_mag    = '0;
    w_sign   = '0;
    w_d      = '0;
    w_b      = '0;
    w_full   = '0;
    w_shift  = '0;
    w_sticky = '0;
    w_err    = '0;
    for (int l = 0; l < LANES; l++) begin
      w_mag[l]  = bus.i_pp[l*(PP_W+1) +: PP_W];
      w_sign[l] = bus.i_pp[l*(PP_W+1) + PP_W];
      {w_b[l], w_d[l]} = {1'b0, bus.i_max_exp} - {1'b0, bus.i_exp[l*EXP_W +: EXP_W]};
      w_full[l] = {w_mag[l], {SH{1'b0}}};
      if (w_b[l]) begin
        // Lane exponent above the beat maximum: flag it and contribute nothing.
        w_err[l] = 1'b1;
      end else if (int'(w_d[l]) < ALIGN_W) begin
        w_shift[l] = w_full[l] >> w_d[l];
        for (int k = 0; k < ALIGN_W; k++) begin
          if (k < int'(w_d[l])) w_sticky[l] = w_sticky[l] | w_full[l][k];
        end
      end else begin
        // Everything shifts out; only the sticky survives.
        w_sticky[l] = |w_mag[l];
      end
    end
  end

  // Stage 2 combinational: sign-magnitude to two's complement; negative zero wraps to 0.
  always_comb begin
    w_tc = '0;
    for (int l = 0; l < LANES; l++) begin
      w_tc[l] = r_s1_sign[l] ? (~{1'b0, r_s1_shift[l]}) + OW'(1) : {1'b0, r_s1_shift[l]};
    end
  end

  // Stage 1 registers: valid follows any advance, data loads only on an accepted beat.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_shift   <= '0;
      r_s1_sign    <= '0;
      r_s1_sticky  <= '0;
      r_s1_err     <= '0;
      r_s1_max_exp <= '0;
      r_s1_qf      <= '0;
    end else begin
      if (bus.o_ready) r_s1_valid <= bus.i_valid;
      if (w_acc) begin
        r_s1_shift   <= w_shift;
        r_s1_sign    <= w_sign;
        r_s1_sticky  <= w_sticky;
        r_s1_err     <= w_err;
        r_s1_max_exp <= bus.i_max_exp;
        r_s1_qf      <= bus.i_Q_frac;
      end
    end
  end

  // Stage 2 registers: hold while stalled so outputs stay stable.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s2_valid   <= 1'b0;
      r_s2_align   <= '0;
      r_s2_sticky  <= '0;
      r_s2_err     <= '0;
      r_s2_max_exp <= '0;
      r_s2_qf      <= '0;
    end else begin
      if (w_adv2) r_s2_valid <= r_s1_valid;
      if (w_load2) begin
        r_s2_align   <= w_tc;
        r_s2_sticky  <= r_s1_sticky;
        r_s2_err     <= r_s1_err;
        r_s2_max_exp <= r_s1_max_exp;
        r_s2_qf      <= r_s1_qf;
      end
    end
  end

  assign bus.o_valid    = r_s2_valid;
  assign bus.o_align_pp = r_s2_align;
  assign bus.o_sticky   = r_s2_sticky;
  assign bus.o_exp_err  = r_s2_err;
  assign bus.o_max_exp  = r_s2_max_exp;
  assign bus.o_Q_frac   = r_s2_qf;
endmodule

// File: tb/tb_align_pp_lanes_pipe.sv
// Directed-vector bench with a queue scoreboard for align_pp_lanes_pipe.
// Driver pushes expected beats on accept; monitor pops and compares on each consume.
// Also watches stall stability, o_ready drop depth, latency and reset behaviour.
module tb_align_pp_lanes_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  align_pp_lanes_pipe_if bus ();

  align_pp_lanes_pipe dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] pp;
    logic [23:0] ex;
    logic [5:0]  mx;
    logic [59:0] ap;
    logic [3:0]  st;
    logic [3:0]  er;
  } vec_t;

  typedef struct {
    logic [59:0] ap;
    logic [3:0]  st;
    logic [3:0]  er;
    logic [5:0]  mx;
    logic [4:0]  qf;
    int          acc_cyc;
    bit          lat;
  } exp_t;

  vec_t vecs [4];
  exp_t q [$];
  int   n_chk = 0;
  int   n_err = 0;
  int   n_acc = 0;
  int   n_cons = 0;
  int   ready_drops = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Present one beat and hold it until accepted; expected result is pushed on accept.
  task automatic send(input int idx, input logic [4:0] qf, input bit lat);
    int   w;
    exp_t e;
    w = 0;
    @(negedge clk);
    bus.i_valid   = 1'b1;
    bus.i_pp      = vecs[idx].pp;
    bus.i_exp     = vecs[idx].ex;
    bus.i_max_exp = vecs[idx].mx;
    bus.i_Q_frac  = qf;
    #3;
    while (!bus.o_ready && w < 50) begin
      w++;
      @(negedge clk);
      #3;
    end
    chk("accept_timeout", 64'(bus.o_ready), 64'd1);
    if (bus.o_ready) begin
      e.ap = vecs[idx].ap; e.st = vecs[idx].st; e.er = vecs[idx].er;
      e.mx = vecs[idx].mx; e.qf = qf; e.acc_cyc = cyc; e.lat = lat;
      q.push_back(e);
      n_acc++;
    end
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  // Monitor: samples just before each rising edge.
  logic        prev_stall = 1'b0;
  logic [59:0] prev_ap;
  logic [3:0]  prev_st, prev_er;
  logic [5:0]  prev_mx;
  logic [4:0]  prev_qf;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (prev_stall) begin
        chk("stall_valid", 64'(bus.o_valid), 64'd1);
        chk("stall_stable", {bus.o_align_pp, bus.o_sticky}, {prev_ap, prev_st});
        chk("stall_stable_side", {bus.o_exp_err, bus.o_max_exp, bus.o_Q_frac}, {prev_er, prev_mx, prev_qf});
      end
      if (!rst && !bus.o_ready) begin
        ready_drops++;
        chk("ready_drop_depth", 64'(n_acc - n_cons), 64'd2);
      end
      if (!rst && bus.o_valid && bus.i_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          n_cons++;
          chk("align_pp", bus.o_align_pp, e.ap);
          chk("sticky", bus.o_sticky, e.st);
          chk("exp_err", bus.o_exp_err, e.er);
          chk("sideband", {bus.o_max_exp, bus.o_Q_frac}, {e.mx, e.qf});
          if (e.lat) chk("latency", 64'(cyc - e.acc_cyc), 64'd2);
        end
      end
      prev_stall = bus.o_valid & ~bus.i_ready & ~rst;
      prev_ap = bus.o_align_pp; prev_st = bus.o_sticky; prev_er = bus.o_exp_err;
      prev_mx = bus.o_max_exp;  prev_qf = bus.o_Q_frac;
    end
  end

  task automatic chk_idle(input string nm);
    chk({nm, "_o_valid"}, 64'(bus.o_valid), 64'd0);
    chk({nm, "_o_ready"}, 64'(bus.o_ready), 64'd1);
    chk({nm, "_align"}, bus.o_align_pp, 64'd0);
    chk({nm, "_flags"}, {bus.o_sticky, bus.o_exp_err}, 64'd0);
    chk({nm, "_side"}, {bus.o_max_exp, bus.o_Q_frac}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    // Lanes listed lane3..lane0; pp lane = {sign, mag}.
    vecs[0].pp = {4'b0111, 4'b0110, 4'b1110, 4'b0110};
    vecs[0].ex = {6'd8, 6'd9, 6'd20, 6'd20};
    vecs[0].mx = 6'd20;
    vecs[0].ap = {15'h0003, 15'h0006, 15'h5000, 15'h3000};
    vecs[0].st = 4'b1000;
    vecs[0].er = 4'b0000;

    vecs[1].pp = {4'b1111, 4'b1111, 4'b0110, 4'b0111};
    vecs[1].ex = {6'd8, 6'd21, 6'd21, 6'd6};
    vecs[1].mx = 6'd20;
    vecs[1].ap = {15'h7FFD, 15'h0000, 15'h0000, 15'h0000};
    vecs[1].st = 4'b1001;
    vecs[1].er = 4'b0110;

    vecs[2].pp = {4'b0000, 4'b0100, 4'b1001, 4'b0001};
    vecs[2].ex = {6'd0, 6'd63, 6'd0, 6'd0};
    vecs[2].mx = 6'd0;
    vecs[2].ap = {15'h0000, 15'h0000, 15'h7800, 15'h0800};
    vecs[2].st = 4'b0000;
    vecs[2].er = 4'b0100;

    vecs[3].pp = {4'b0100, 4'b0010, 4'b0111, 4'b1101};
    vecs[3].ex = {6'd62, 6'd50, 6'd63, 6'd0};
    vecs[3].mx = 6'd63;
    vecs[3].ap = {15'h1000, 15'h0000, 15'h3800, 15'h0000};
    vecs[3].st = 4'b0101;
    vecs[3].er = 4'b0000;

    bus.i_valid = 1'b0; bus.i_ready = 1'b1;
    bus.i_pp = '0; bus.i_exp = '0; bus.i_max_exp = '0; bus.i_Q_frac = '0;

    // Reset state.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #3 chk_idle("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single beats, unstalled.
    for (int i = 0; i < 4; i++) begin
      send(i, 5'(i + 1), 1'b1);
      drain();
    end

    // Back-to-back, unstalled.
    for (int i = 0; i < 4; i++) send(3 - i, 5'(i + 10), 1'b1);
    drain();

    // Six-beat stream with i_ready low for cycles 3-5.
    ready_drops = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(i % 4, 5'(i + 20), 1'b0);
      end
      begin
        repeat (3) @(negedge clk);
        bus.i_ready = 1'b0;
        repeat (3) @(negedge clk);
        bus.i_ready = 1'b1;
      end
    join
    drain();
    chk("stream_ready_dropped", 64'(ready_drops > 0), 64'd1);
    chk("stream_all_consumed", 64'(n_cons), 64'(n_acc));

    // Reset with two beats in flight.
    @(negedge clk);
    bus.i_ready = 1'b0;
    send(1, 5'd30, 1'b0);
    send(2, 5'd31, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    n_acc = 0;
    n_cons = 0;
    #3 chk_idle("post_reset");
    bus.i_ready = 1'b1;
    send(0, 5'd7, 1'b1);
    drain();

    chk("queue_empty_end", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
